// File: rtl/sd_cmd_tx_pkg.sv
// Shared SD definitions: frame geometry, CRC7 polynomial, transmitter state
// encoding and a helper that assembles the fixed part of a command frame.
package sd_cmd_tx_pkg;

   localparam int SD_CMD_FRAME_BITS   = 48;
   localparam int SD_CMD_PAYLOAD_BITS = 40;
   localparam int SD_CRC7_BITS        = 7;

   // x^7 + x^3 + 1, with the x^7 term implied by the shift-out.
   localparam logic [SD_CRC7_BITS-1:0] SD_CRC7_POLY = 7'h09;

   // Transmitter states.
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SEND = 3'd1;
   localparam logic [2:0] ST_CRC  = 3'd2;
   localparam logic [2:0] ST_END  = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;

   // Start bit, transmission bit, index and argument. The CRC field is left
   // zero; it is sent from the CRC7 block and never from this register.
   function automatic logic [SD_CMD_FRAME_BITS-1:0] sd_cmd_header(
      input logic [5:0]  index,
      input logic [31:0] arg
   );
      return {1'b0, 1'b1, index, arg, {SD_CRC7_BITS{1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/sd_cmd_tx_crc7.sv
// Serial CRC7 generator for SD command frames. While en=1 each cycle shifts
// one message bit in; while en=0 the remainder is cleared, so a fresh frame
// always starts from zero.
module sd_cmd_tx_crc7
   import sd_cmd_tx_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    din,
   output logic [SD_CRC7_BITS-1:0] d
);

   logic fb;

   assign fb = din ^ d[SD_CRC7_BITS-1];

   // Shift the remainder with feedback, or hold it at zero when disabled.
   always_ff @(posedge clk) begin
      // NOTE: clocked blocks use <= so every register samples pre-edge values.
      if (rst || !en) begin
         d <= '0;
      end else begin
         d <= {d[SD_CRC7_BITS-2:0], 1'b0} ^ (fb ? SD_CRC7_POLY : '0);
      end
   end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter. Serialises {start, dir, index, arg, crc7, end}
// MSB-first at one bit per clock, then holds the line high for GAP_BITS
// cycles before releasing it and pulsing done.
module sd_cmd_tx
   import sd_cmd_tx_pkg::*;
#(
   parameter int GAP_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        sd_cmd_out,
   output logic        sd_cmd_oe,
   output logic        done
);

   localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [5:0] SEND_INIT = 6'(SD_CMD_PAYLOAD_BITS - 1);
   localparam logic [5:0] CRC_INIT  = 6'(SD_CRC7_BITS - 1);

   logic [2:0]                   state;
   logic [SD_CMD_FRAME_BITS-1:0] shreg;
   logic [5:0]                   bit_cnt;
   logic [GAP_W-1:0]             gap_cnt;
   logic [SD_CRC7_BITS-1:0]      crc_sh;
   logic [SD_CRC7_BITS-1:0]      crc_d;
   logic                         crc_en;
   logic                         accept;

   // Ready only in IDLE and never while reset is held.
   assign cmd_ready = (state == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign crc_en    = (state == ST_SEND);
   assign sd_cmd_oe = (state != ST_IDLE);

   sd_cmd_tx_crc7 u_crc7 (
      .clk (clk),
      .rst (rst),
      .en  (crc_en),
      .din (shreg[SD_CMD_FRAME_BITS-1]),
      .d   (crc_d)
   );

   // Frame sequencer: loads the command, walks SEND/CRC/END/GAP, pulses done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         crc_sh  <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shreg   <= sd_cmd_header(cmd_index, cmd_arg);
                  bit_cnt <= SEND_INIT;
                  state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               shreg <= shreg << 1;
               if (bit_cnt == 6'd0) begin
                  bit_cnt <= CRC_INIT;
                  state   <= ST_CRC;
               end else begin
                  bit_cnt <= bit_cnt - 6'd1;
               end
            end
            ST_CRC: begin
               // First CRC cycle sends crc_d[6] directly and parks the rest,
               // since the CRC block clears itself once SEND is left.
               if (bit_cnt == CRC_INIT) begin
                  crc_sh <= {crc_d[SD_CRC7_BITS-2:0], 1'b0};
               end else begin
                  crc_sh <= {crc_sh[SD_CRC7_BITS-2:0], 1'b0};
               end
               if (bit_cnt == 6'd0) begin
                  state <= ST_END;
               end else begin
                  bit_cnt <= bit_cnt - 6'd1;
               end
            end
            ST_END: begin
               if (GAP_BITS == 0) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else begin
                  gap_cnt <= GAP_INIT;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Line data is a pure mux of registered state; idle line sits high.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      sd_cmd_out = 1'b1;
      case (state)
         ST_SEND: sd_cmd_out = shreg[SD_CMD_FRAME_BITS-1];
         ST_CRC:  sd_cmd_out = (bit_cnt == CRC_INIT) ? crc_d[SD_CRC7_BITS-1]
                                                     : crc_sh[SD_CRC7_BITS-1];
         default: sd_cmd_out = 1'b1;
      endcase
   end

endmodule
